// File: rtl/uart_frame_recv.sv
// UART frame receiver: assembles FRAME_BYTES bytes from uart_rxd into frame_data.
// Ports: sys_clk/sys_rst_n, uart_rxd in; rx_byte/valid, frame_data/valid, frame_err/err_code, rx_busy, byte_cnt out.
`timescale 1ns/1ps
module uart_frame_recv #(
  parameter int          CLK_FREQ     = 50000000,
  parameter int          UART_BPS     = 9600,
  parameter int          FRAME_BYTES  = 8,
  parameter bit          LSB_FIRST    = 1'b1,
  parameter bit          USE_HEADER   = 1'b0,
  parameter logic [7:0]  HEADER       = 8'hA5,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst_n,
  input  logic                               uart_rxd,
  output logic [7:0]                         rx_byte,
  output logic                               rx_byte_valid,
  output logic [8*FRAME_BYTES-1:0]           frame_data,
  output logic                               frame_valid,
  output logic                               frame_err,
  output logic [1:0]                         err_code,
  output logic                               rx_busy,
  output logic [$clog2(FRAME_BYTES+1)-1:0]   byte_cnt
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int HALF    = BPS_CNT / 2;
  localparam int BW0     = $clog2(BPS_CNT + 1);
  localparam int BW      = (BW0 > 16) ? BW0 : 16;
  localparam int TO_MAX  = TIMEOUT_BITS * BPS_CNT;
  localparam int TW      = $clog2(TO_MAX + 1);
  localparam int CW      = $clog2(FRAME_BYTES + 1);
  localparam int FW      = 8 * FRAME_BYTES;

  typedef enum logic [1:0] {
    B_IDLE, B_START, B_DATA, B_STOP
  } bstate_t;

  typedef enum logic {
    F_HUNT, F_COLLECT
  } fstate_t;

  localparam fstate_t START_ST =
    USE_HEADER ? F_HUNT : F_COLLECT;

  logic          sync1, sync2, sync3;
  logic          fall;
  bstate_t       bst, bst_nx;
  logic [BW-1:0] bit_tmr;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          half_hit, full_hit;
  logic          stop_hit;
  logic          fe_q;

  // synchroniser preset to idle so reset never looks like a start bit
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= uart_rxd;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign fall     = sync3 & ~sync2;
  assign half_hit = (bit_tmr == BW'(HALF - 1));
  assign full_hit = (bit_tmr == BW'(BPS_CNT - 1));
  assign stop_hit = (bst == B_STOP) && full_hit;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) bst <= B_IDLE;
    else            bst <= bst_nx;
  end

  always_comb begin
    bst_nx = bst;
    unique case (bst)
      B_IDLE:  if (fall) bst_nx = B_START;
      B_START: if (half_hit)
                 bst_nx = sync2 ? B_IDLE : B_DATA;
      B_DATA:  if (full_hit && bit_idx == 3'd7)
                 bst_nx = B_STOP;
      B_STOP:  if (full_hit) bst_nx = B_IDLE;
      default: bst_nx = B_IDLE;
    endcase
  end

  // timer restarts at mid start bit, so every full period lands mid-bit
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_tmr       <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      fe_q          <= 1'b0;
    end else begin
      if (bst == B_IDLE || bst_nx != bst || full_hit)
        bit_tmr <= '0;
      else
        bit_tmr <= bit_tmr + BW'(1);
      if (bst != B_DATA)
        bit_idx <= '0;
      else if (full_hit)
        bit_idx <= bit_idx + 3'd1;
      if (bst == B_DATA && full_hit)
        shreg <= {sync2, shreg[7:1]};
      rx_byte_valid <= stop_hit & sync2;
      fe_q          <= stop_hit & ~sync2;
      if (stop_hit & sync2)
        rx_byte <= shreg;
    end
  end

  fstate_t       fst, fst_nx;
  logic [FW-1:0] tmp, merged;
  logic          hdr_ok;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          store, done, hdr_hit, abort;
  logic [1:0]    code;
  int            lane;

  assign rx_busy = hdr_ok | (byte_cnt != '0);
  assign to_hit  = rx_busy && (to_cnt == TW'(TO_MAX - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) fst <= START_ST;
    else            fst <= fst_nx;
  end

  always_comb begin
    lane = LSB_FIRST ? int'(byte_cnt)
                     : FRAME_BYTES - 1 - int'(byte_cnt);
    merged = tmp;
    for (int i = 0; i < FRAME_BYTES; i++)
      if (i == lane) merged[8*i +: 8] = rx_byte;
  end

  // a good byte outranks a coincident timeout
  always_comb begin
    fst_nx  = fst;
    store   = 1'b0;
    done    = 1'b0;
    hdr_hit = 1'b0;
    abort   = 1'b0;
    code    = 2'b00;
    unique case (fst)
      F_HUNT: begin
        if (rx_byte_valid && rx_byte == HEADER) begin
          hdr_hit = 1'b1;
          fst_nx  = F_COLLECT;
        end
      end
      F_COLLECT: begin
        unique case (1'b1)
          rx_byte_valid: begin
            store = 1'b1;
            if (byte_cnt == CW'(FRAME_BYTES - 1)) begin
              done   = 1'b1;
              fst_nx = START_ST;
            end
          end
          fe_q && rx_busy: begin
            abort  = 1'b1;
            code   = 2'b01;
            fst_nx = START_ST;
          end
          to_hit: begin
            abort  = 1'b1;
            code   = 2'b10;
            fst_nx = START_ST;
          end
          default: ;
        endcase
      end
      default: fst_nx = START_ST;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmp         <= '0;
      byte_cnt    <= '0;
      hdr_ok      <= 1'b0;
      to_cnt      <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      frame_valid <= done;
      frame_err   <= abort;
      if (abort) err_code <= code;
      if (done)  frame_data <= merged;
      if (done || abort) begin
        tmp      <= '0;
        byte_cnt <= '0;
      end else if (store) begin
        tmp      <= merged;
        byte_cnt <= byte_cnt + CW'(1);
      end
      if (hdr_hit)            hdr_ok <= 1'b1;
      else if (done || abort) hdr_ok <= 1'b0;
      if (!rx_busy || rx_byte_valid || abort)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_uart_frame_recv.sv
// Directed bench for uart_frame_recv: three instances (default, MSB-first 4-byte, header).
// Ports: none; drives serial lines and checks frames, errors and pulse timing.
`timescale 1ns/1ps
module tb_uart_frame_recv;

  localparam int BPS = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rxd = 3'b111;

  always #5 clk = ~clk;

  logic [7:0]  a_rb, m_rb, h_rb;
  logic        a_rbv, m_rbv, h_rbv;
  logic [63:0] a_fd, h_fd;
  logic [31:0] m_fd;
  logic        a_fv, m_fv, h_fv;
  logic        a_fe, m_fe, h_fe;
  logic [1:0]  a_ec, m_ec, h_ec;
  logic        a_bz, m_bz, h_bz;
  logic [3:0]  a_bc, h_bc;
  logic [2:0]  m_bc;

  uart_frame_recv #(
    .CLK_FREQ(6400000), .UART_BPS(100000)
  ) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd[0]),
    .rx_byte(a_rb), .rx_byte_valid(a_rbv),
    .frame_data(a_fd), .frame_valid(a_fv),
    .frame_err(a_fe), .err_code(a_ec),
    .rx_busy(a_bz), .byte_cnt(a_bc)
  );

  uart_frame_recv #(
    .CLK_FREQ(6400000), .UART_BPS(100000),
    .FRAME_BYTES(4), .LSB_FIRST(1'b0)
  ) dut_m (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd[1]),
    .rx_byte(m_rb), .rx_byte_valid(m_rbv),
    .frame_data(m_fd), .frame_valid(m_fv),
    .frame_err(m_fe), .err_code(m_ec),
    .rx_busy(m_bz), .byte_cnt(m_bc)
  );

  uart_frame_recv #(
    .CLK_FREQ(6400000), .UART_BPS(100000),
    .USE_HEADER(1'b1), .HEADER(8'hA5)
  ) dut_h (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd[2]),
    .rx_byte(h_rb), .rx_byte_valid(h_rbv),
    .frame_data(h_fd), .frame_valid(h_fv),
    .frame_err(h_fe), .err_code(h_ec),
    .rx_busy(h_bz), .byte_cnt(h_bc)
  );

  int checks = 0;
  int failures = 0;
  int a_nrbv = 0, a_nfv = 0, a_nfe = 0;
  int m_nrbv = 0, m_nfv = 0, m_nfe = 0;
  int h_nrbv = 0, h_nfv = 0, h_nfe = 0;
  int lat_bad = 0, ovl = 0;
  logic a_d = 1'b0, m_d = 1'b0, h_d = 1'b0;

  always @(negedge clk) begin
    a_nrbv += int'(a_rbv); a_nfv += int'(a_fv);
    a_nfe  += int'(a_fe);
    m_nrbv += int'(m_rbv); m_nfv += int'(m_fv);
    m_nfe  += int'(m_fe);
    h_nrbv += int'(h_rbv); h_nfv += int'(h_fv);
    h_nfe  += int'(h_fe);
    if (a_fv && !a_d) lat_bad++;
    if (m_fv && !m_d) lat_bad++;
    if (h_fv && !h_d) lat_bad++;
    if ((a_fv && a_fe) || (m_fv && m_fe) || (h_fv && h_fe))
      ovl++;
    a_d = a_rbv; m_d = m_rbv; h_d = h_rbv;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input int sel,
                      input logic [7:0] b,
                      input logic stop);
    @(negedge clk);
    rxd[sel] = 1'b0;
    repeat (BPS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd[sel] = b[i];
      repeat (BPS) @(negedge clk);
    end
    rxd[sel] = stop;
    repeat (BPS) @(negedge clk);
    rxd[sel] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(5);
    chk("rst_fd", a_fd, 64'h0);
    chk("rst_bc", 64'(a_bc), 64'h0);
    chk("rst_ec", 64'(a_ec), 64'h0);
    chk("rst_rb", 64'(a_rb), 64'h0);
    rst_n = 1'b1;
    idle(5);
    chk("idle_bz", 64'(a_bz), 64'h0);

    for (int i = 1; i <= 8; i++) send(0, 8'(i), 1'b1);
    idle(4);
    chk("t1_fd", a_fd, 64'h0807060504030201);
    chk("t1_nrbv", 64'(a_nrbv), 64'd8);
    chk("t1_nfv", 64'(a_nfv), 64'd1);
    chk("t1_bc", 64'(a_bc), 64'h0);
    chk("t1_bz", 64'(a_bz), 64'h0);

    send(0, 8'h11, 1'b1);
    send(0, 8'h22, 1'b1);
    idle(2);
    chk("t4_bc2", 64'(a_bc), 64'd2);
    send(0, 8'h33, 1'b0);
    idle(4);
    chk("t4_nrbv", 64'(a_nrbv), 64'd10);
    chk("t4_nfe", 64'(a_nfe), 64'd1);
    chk("t4_ec", 64'(a_ec), 64'h1);
    chk("t4_bc0", 64'(a_bc), 64'h0);
    for (int i = 0; i < 8; i++)
      send(0, 8'h40 + 8'(i), 1'b1);
    idle(4);
    chk("t4_fd", a_fd, 64'h4746454443424140);
    chk("t4_nfv", 64'(a_nfv), 64'd2);

    rxd[0] = 1'b0;
    idle(20);
    rxd[0] = 1'b1;
    idle(2 * 10 * BPS);
    chk("t5_nrbv", 64'(a_nrbv), 64'd18);
    chk("t5_bc", 64'(a_bc), 64'h0);
    chk("t5_nfe", 64'(a_nfe), 64'd1);

    send(1, 8'hDE, 1'b1);
    send(1, 8'hAD, 1'b1);
    send(1, 8'hBE, 1'b1);
    send(1, 8'hEF, 1'b1);
    idle(4);
    chk("t2_fd", 64'(m_fd), 64'hDEADBEEF);
    chk("t2_nfv", 64'(m_nfv), 64'd1);
    send(1, 8'h01, 1'b1);
    send(1, 8'h02, 1'b1);
    send(1, 8'h03, 1'b1);
    idle(2);
    chk("t2_bc3", 64'(m_bc), 64'd3);
    chk("t2_bz", 64'(m_bz), 64'h1);
    idle(25 * BPS);
    chk("t2_nfe", 64'(m_nfe), 64'd1);
    chk("t2_ec", 64'(m_ec), 64'h2);
    chk("t2_fd_hold", 64'(m_fd), 64'hDEADBEEF);
    chk("t2_bc0", 64'(m_bc), 64'h0);

    send(2, 8'h11, 1'b1);
    idle(2);
    chk("t3_rb", 64'(h_rb), 64'h11);
    chk("t3_bz0", 64'(h_bz), 64'h0);
    send(2, 8'hA5, 1'b1);
    idle(2);
    chk("t3_bz1", 64'(h_bz), 64'h1);
    chk("t3_bc", 64'(h_bc), 64'h0);
    for (int i = 0; i < 8; i++)
      send(2, 8'h10 + 8'(i), 1'b1);
    idle(4);
    chk("t3_fd", h_fd, 64'h1716151413121110);
    chk("t3_nfv", 64'(h_nfv), 64'd1);
    chk("t3_nrbv", 64'(h_nrbv), 64'd10);
    chk("t3_bzend", 64'(h_bz), 64'h0);

    for (int i = 0; i < 5; i++)
      send(0, 8'h50 + 8'(i), 1'b1);
    idle(2);
    chk("t6_bc5", 64'(a_bc), 64'd5);
    rst_n = 1'b0;
    idle(3);
    chk("t6_fd", a_fd, 64'h0);
    chk("t6_bc", 64'(a_bc), 64'h0);
    chk("t6_ec", 64'(a_ec), 64'h0);
    chk("t6_bz", 64'(a_bz), 64'h0);
    chk("t6_rb", 64'(a_rb), 64'h0);
    rst_n = 1'b1;
    idle(3);
    for (int i = 0; i < 8; i++)
      send(0, 8'h60 + 8'(i), 1'b1);
    idle(4);
    chk("t6_fd2", a_fd, 64'h6766656463626160);
    chk("t6_nfe", 64'(a_nfe), 64'd1);
    chk("t6_nfv", 64'(a_nfv), 64'd3);

    chk("latency", 64'(lat_bad), 64'd0);
    chk("fv_fe_ovl", 64'(ovl), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
